vxe_axi4mas_biu_ot: RTL and testbench



---
 rtl/vxe_axi4mas_pkg.sv | 42 ++++
 rtl/vxe_axi4mas_otcnt.sv | 44 ++++
 rtl/vxe_axi4mas_biu_ot.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_vxe_axi4mas_biu_ot.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vxe_axi4mas_pkg.sv
// Shared constants and helpers for the VxEngine AXI4 master BIU.
// AXI response codes, fixed attribute values and the beat-size helper.
package vxe_axi4mas_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [7:0] LEN_SINGLE  = 8'h00;
    localparam logic [3:0] CACHE_DEVNB = 4'b0000;
    localparam logic [2:0] PROT_NSEC   = 3'b010;

    // AxSIZE encoding for a full-width beat of dw bits (8..1024).
    function automatic logic [2:0] bsz_log2(input int unsigned dw);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd8 << i) == dw) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

    // SLVERR and DECERR are the error responses.
    function automatic logic resp_is_err(input logic [1:0] r);
        logic e;
        e = 1'b0;
        unique case (r)
            RESP_OKAY, RESP_EXOKAY:  e = 1'b0;
            RESP_SLVERR, RESP_DECERR: e = 1'b1;
            default:                 e = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/vxe_axi4mas_otcnt.sv
// Outstanding-transaction credit counter for one AXI direction.
// Counts up on issue, down on response, never underflows.
module vxe_axi4mas_otcnt
    import vxe_axi4mas_pkg::*;
#(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         full_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: inc and dec together cancel; dec at zero holds zero.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == W'(MAX));
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vxe_axi4mas_biu_ot.sv
// Pipelined single-beat AXI4 master BIU with per-direction credit limit.
// Optional error counters: define VXE_AXI4MAS_BIU_ERRCNT_EN.
module vxe_axi4mas_biu_ot
    import vxe_axi4mas_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned CID_WIDTH  = 8,
    parameter int unsigned MAX_OUTST  = 4,
    localparam int unsigned CNT_W     = $clog2(MAX_OUTST + 1),
    localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  M_AXI4_ACLK,
    input  logic                  M_AXI4_ARESET,

    output logic [ID_WIDTH-1:0]   M_AXI4_AWID,
    output logic [ADDR_WIDTH-1:0] M_AXI4_AWADDR,
    output logic [7:0]            M_AXI4_AWLEN,
    output logic [2:0]            M_AXI4_AWSIZE,
    output logic [1:0]            M_AXI4_AWBURST,
    output logic                  M_AXI4_AWLOCK,
    output logic [3:0]            M_AXI4_AWCACHE,
    output logic [2:0]            M_AXI4_AWPROT,
    output logic                  M_AXI4_AWVALID,
    input  logic                  M_AXI4_AWREADY,

    output logic [DATA_WIDTH-1:0] M_AXI4_WDATA,
    output logic [STRB_W-1:0]     M_AXI4_WSTRB,
    output logic                  M_AXI4_WLAST,
    output logic                  M_AXI4_WVALID,
    input  logic                  M_AXI4_WREADY,

    input  logic [ID_WIDTH-1:0]   M_AXI4_BID,
    input  logic [1:0]            M_AXI4_BRESP,
    input  logic                  M_AXI4_BVALID,
    output logic                  M_AXI4_BREADY,

    output logic [ID_WIDTH-1:0]   M_AXI4_ARID,
    output logic [ADDR_WIDTH-1:0] M_AXI4_ARADDR,
    output logic [7:0]            M_AXI4_ARLEN,
    output logic [2:0]            M_AXI4_ARSIZE,
    output logic [1:0]            M_AXI4_ARBURST,
    output logic                  M_AXI4_ARLOCK,
    output logic [3:0]            M_AXI4_ARCACHE,
    output logic [2:0]            M_AXI4_ARPROT,
    output logic                  M_AXI4_ARVALID,
    input  logic                  M_AXI4_ARREADY,

    input  logic [ID_WIDTH-1:0]   M_AXI4_RID,
    input  logic [DATA_WIDTH-1:0] M_AXI4_RDATA,
    input  logic [1:0]            M_AXI4_RRESP,
    input  logic                  M_AXI4_RLAST,
    input  logic                  M_AXI4_RVALID,
    output logic                  M_AXI4_RREADY,

    input  logic [CID_WIDTH-1:0]  biu_awcid,
    input  logic [ADDR_WIDTH-1:0] biu_awaddr,
    input  logic [DATA_WIDTH-1:0] biu_awdata,
    input  logic [STRB_W-1:0]     biu_awstrb,
    input  logic                  biu_awvalid,
    output logic                  biu_awpop,

    output logic [CID_WIDTH-1:0]  biu_bcid,
    output logic [1:0]            biu_bresp,
    output logic                  biu_bpush,
    input  logic                  biu_bready,

    input  logic [CID_WIDTH-1:0]  biu_arcid,
    input  logic [ADDR_WIDTH-1:0] biu_araddr,
    input  logic                  biu_arvalid,
    output logic                  biu_arpop,

    output logic [CID_WIDTH-1:0]  biu_rcid,
    output logic [DATA_WIDTH-1:0] biu_rdata,
    output logic [1:0]            biu_rresp,
    output logic                  biu_rpush,
    input  logic                  biu_rready,

    output logic [CNT_W-1:0]      wr_outst,
    output logic [CNT_W-1:0]      rd_outst,
`ifdef VXE_AXI4MAS_BIU_ERRCNT_EN
    input  logic                  err_clr,
    output logic [15:0]           wr_errcnt,
    output logic [15:0]           rd_errcnt,
`endif
    output logic                  biu_idle
);

    localparam logic [2:0] AX_SIZE = bsz_log2(DATA_WIDTH);

    logic                  clk;
    logic                  rst;

    logic [ID_WIDTH-1:0]   awid_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;

    logic [ID_WIDTH-1:0]   arid_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arvalid_q, arvalid_d;

    logic [CID_WIDTH-1:0]  bcid_q;
    logic [1:0]            bresp_q;
    logic                  bpush_q;
    logic [CID_WIDTH-1:0]  rcid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rpush_q;

    logic                  wr_free, wr_issue, wr_full, wr_zero;
    logic                  rd_free, rd_issue, rd_full, rd_zero;
    logic                  b_hs, r_hs;
    logic                  unused_sig;

    assign clk = M_AXI4_ACLK;
    assign rst = M_AXI4_ARESET;

    // Upper ID bits and RLAST carry no information for single-beat use.
    assign unused_sig = ^{M_AXI4_BID, M_AXI4_RID, M_AXI4_RLAST};

    assign b_hs = M_AXI4_BVALID && biu_bready;
    assign r_hs = M_AXI4_RVALID && biu_rready;

    // A channel pair is free once every pending valid is accepted now.
    assign wr_free  = (!awvalid_q || M_AXI4_AWREADY)
                   && (!wvalid_q || M_AXI4_WREADY);
    assign wr_issue = wr_free && biu_awvalid && !wr_full;
    assign rd_free  = !arvalid_q || M_AXI4_ARREADY;
    assign rd_issue = rd_free && biu_arvalid && !rd_full;

    // Write valids: issue sets both, each drops on its own handshake.
    always_comb begin
        awvalid_d = awvalid_q && !M_AXI4_AWREADY;
        wvalid_d  = wvalid_q && !M_AXI4_WREADY;
        if (wr_issue) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end else if (wr_free) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
        end
    end

    // Read valid: issue sets, handshake clears.
    always_comb begin
        arvalid_d = arvalid_q && !M_AXI4_ARREADY;
        if (rd_issue) begin
            arvalid_d = 1'b1;
        end else if (rd_free) begin
            arvalid_d = 1'b0;
        end
    end

    // Write address/data registers, loaded on issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awid_q    <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            if (wr_issue) begin
                awid_q   <= ID_WIDTH'(biu_awcid);
                awaddr_q <= biu_awaddr;
                wdata_q  <= biu_awdata;
                wstrb_q  <= biu_awstrb;
            end
        end
    end

    // Read address registers, loaded on issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arid_q    <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            if (rd_issue) begin
                arid_q   <= ID_WIDTH'(biu_arcid);
                araddr_q <= biu_araddr;
            end
        end
    end

    // Write response capture with a one-cycle push pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcid_q  <= '0;
            bresp_q <= '0;
            bpush_q <= 1'b0;
        end else begin
            bpush_q <= b_hs;
            if (b_hs) begin
                bcid_q  <= M_AXI4_BID[CID_WIDTH-1:0];
                bresp_q <= M_AXI4_BRESP;
            end
        end
    end

    // Read response capture with a one-cycle push pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcid_q  <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
            rpush_q <= 1'b0;
        end else begin
            rpush_q <= r_hs;
            if (r_hs) begin
                rcid_q  <= M_AXI4_RID[CID_WIDTH-1:0];
                rdata_q <= M_AXI4_RDATA;
                rresp_q <= M_AXI4_RRESP;
            end
        end
    end

    vxe_axi4mas_otcnt #(
        .MAX (MAX_OUTST),
        .W   (CNT_W)
    ) u_wr_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .inc_i  (wr_issue),
        .dec_i  (b_hs),
        .cnt_o  (wr_outst),
        .full_o (wr_full),
        .zero_o (wr_zero)
    );

    vxe_axi4mas_otcnt #(
        .MAX (MAX_OUTST),
        .W   (CNT_W)
    ) u_rd_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .inc_i  (rd_issue),
        .dec_i  (r_hs),
        .cnt_o  (rd_outst),
        .full_o (rd_full),
        .zero_o (rd_zero)
    );

`ifdef VXE_AXI4MAS_BIU_ERRCNT_EN
    logic [15:0] wr_errcnt_q;
    logic [15:0] rd_errcnt_q;

    // Saturating error-response counters; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_errcnt_q <= '0;
            rd_errcnt_q <= '0;
        end else if (err_clr) begin
            wr_errcnt_q <= '0;
            rd_errcnt_q <= '0;
        end else begin
            if (b_hs && resp_is_err(M_AXI4_BRESP)
                && (wr_errcnt_q != 16'hFFFF)) begin
                wr_errcnt_q <= wr_errcnt_q + 16'd1;
            end
            if (r_hs && resp_is_err(M_AXI4_RRESP)
                && (rd_errcnt_q != 16'hFFFF)) begin
                rd_errcnt_q <= rd_errcnt_q + 16'd1;
            end
        end
    end

    assign wr_errcnt = wr_errcnt_q;
    assign rd_errcnt = rd_errcnt_q;
`endif

    assign M_AXI4_AWID    = awid_q;
    assign M_AXI4_AWADDR  = awaddr_q;
    assign M_AXI4_AWLEN   = LEN_SINGLE;
    assign M_AXI4_AWSIZE  = AX_SIZE;
    assign M_AXI4_AWBURST = BURST_FIXED;
    assign M_AXI4_AWLOCK  = 1'b0;
    assign M_AXI4_AWCACHE = CACHE_DEVNB;
    assign M_AXI4_AWPROT  = PROT_NSEC;
    assign M_AXI4_AWVALID = awvalid_q;

    assign M_AXI4_WDATA   = wdata_q;
    assign M_AXI4_WSTRB   = wstrb_q;
    assign M_AXI4_WLAST   = 1'b1;
    assign M_AXI4_WVALID  = wvalid_q;

    assign M_AXI4_BREADY  = biu_bready;

    assign M_AXI4_ARID    = arid_q;
    assign M_AXI4_ARADDR  = araddr_q;
    assign M_AXI4_ARLEN   = LEN_SINGLE;
    assign M_AXI4_ARSIZE  = AX_SIZE;
    assign M_AXI4_ARBURST = BURST_FIXED;
    assign M_AXI4_ARLOCK  = 1'b0;
    assign M_AXI4_ARCACHE = CACHE_DEVNB;
    assign M_AXI4_ARPROT  = PROT_NSEC;
    assign M_AXI4_ARVALID = arvalid_q;

    assign M_AXI4_RREADY  = biu_rready;

    assign biu_awpop = wr_issue;
    assign biu_arpop = rd_issue;
    assign biu_bcid  = bcid_q;
    assign biu_bresp = bresp_q;
    assign biu_bpush = bpush_q;
    assign biu_rcid  = rcid_q;
    assign biu_rdata = rdata_q;
    assign biu_rresp = rresp_q;
    assign biu_rpush = rpush_q;

    assign biu_idle = !awvalid_q && !wvalid_q && !arvalid_q
                   && wr_zero && rd_zero;

endmodule

// File: tb/tb_vxe_axi4mas_biu_ot.sv
// Bench for vxe_axi4mas_biu_ot: directed steps plus a random phase,
// scored against a queue-based transaction model.
module tb_vxe_axi4mas_biu_ot;

    localparam int MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWLOCK, ARLOCK;
    logic [3:0]  AWCACHE, ARCACHE, WSTRB;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY;
    logic        BVALID, BREADY, ARVALID, ARREADY;
    logic        RLAST, RVALID, RREADY;

    logic [3:0]  biu_awcid, biu_arcid, biu_bcid, biu_rcid, biu_awstrb;
    logic [31:0] biu_awaddr, biu_awdata, biu_araddr, biu_rdata;
    logic        biu_awvalid, biu_awpop, biu_bpush, biu_bready;
    logic        biu_arvalid, biu_arpop, biu_rpush, biu_rready;
    logic [1:0]  biu_bresp, biu_rresp;
    logic [1:0]  wr_outst, rd_outst;
    logic        biu_idle;
`ifdef VXE_AXI4MAS_BIU_ERRCNT_EN
    logic        err_clr = 1'b0;
    logic [15:0] wr_errcnt, rd_errcnt;
`endif

    vxe_axi4mas_biu_ot #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8),
        .CID_WIDTH(4), .MAX_OUTST(MAX)
    ) dut (
        .M_AXI4_ACLK(clk), .M_AXI4_ARESET(rst),
        .M_AXI4_AWID(AWID), .M_AXI4_AWADDR(AWADDR),
        .M_AXI4_AWLEN(AWLEN), .M_AXI4_AWSIZE(AWSIZE),
        .M_AXI4_AWBURST(AWBURST), .M_AXI4_AWLOCK(AWLOCK),
        .M_AXI4_AWCACHE(AWCACHE), .M_AXI4_AWPROT(AWPROT),
        .M_AXI4_AWVALID(AWVALID), .M_AXI4_AWREADY(AWREADY),
        .M_AXI4_WDATA(WDATA), .M_AXI4_WSTRB(WSTRB),
        .M_AXI4_WLAST(WLAST), .M_AXI4_WVALID(WVALID),
        .M_AXI4_WREADY(WREADY),
        .M_AXI4_BID(BID), .M_AXI4_BRESP(BRESP),
        .M_AXI4_BVALID(BVALID), .M_AXI4_BREADY(BREADY),
        .M_AXI4_ARID(ARID), .M_AXI4_ARADDR(ARADDR),
        .M_AXI4_ARLEN(ARLEN), .M_AXI4_ARSIZE(ARSIZE),
        .M_AXI4_ARBURST(ARBURST), .M_AXI4_ARLOCK(ARLOCK),
        .M_AXI4_ARCACHE(ARCACHE), .M_AXI4_ARPROT(ARPROT),
        .M_AXI4_ARVALID(ARVALID), .M_AXI4_ARREADY(ARREADY),
        .M_AXI4_RID(RID), .M_AXI4_RDATA(RDATA),
        .M_AXI4_RRESP(RRESP), .M_AXI4_RLAST(RLAST),
        .M_AXI4_RVALID(RVALID), .M_AXI4_RREADY(RREADY),
        .biu_awcid(biu_awcid), .biu_awaddr(biu_awaddr),
        .biu_awdata(biu_awdata), .biu_awstrb(biu_awstrb),
        .biu_awvalid(biu_awvalid), .biu_awpop(biu_awpop),
        .biu_bcid(biu_bcid), .biu_bresp(biu_bresp),
        .biu_bpush(biu_bpush), .biu_bready(biu_bready),
        .biu_arcid(biu_arcid), .biu_araddr(biu_araddr),
        .biu_arvalid(biu_arvalid), .biu_arpop(biu_arpop),
        .biu_rcid(biu_rcid), .biu_rdata(biu_rdata),
        .biu_rresp(biu_rresp), .biu_rpush(biu_rpush),
        .biu_rready(biu_rready),
        .wr_outst(wr_outst), .rd_outst(rd_outst),
`ifdef VXE_AXI4MAS_BIU_ERRCNT_EN
        .err_clr(err_clr), .wr_errcnt(wr_errcnt),
        .rd_errcnt(rd_errcnt),
`endif
        .biu_idle(biu_idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  cid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wreq_t;

    typedef struct packed {
        logic [3:0]  cid;
        logic [31:0] addr;
    } rreq_t;

    // Client FIFOs and requests popped but not yet accepted per channel.
    wreq_t wq[$], awp[$], wp[$];
    rreq_t rq[$], arp[$];
    int    wcnt, rcnt, nwpop, nrpop;
    bit    eb_push, er_push;
    logic [3:0]  eb_cid, er_cid;
    logic [1:0]  eb_resp, er_resp;
    logic [31:0] er_data;
    int    ew_err, er_err;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        wq.delete(); awp.delete(); wp.delete();
        rq.delete(); arp.delete();
        wcnt = 0; rcnt = 0;
        eb_push = 0; er_push = 0;
        ew_err = 0; er_err = 0;
    endtask

    // One clock: present client heads, check outputs, advance the model.
    task automatic cyc();
        bit wf, rf, ep_w, ep_r, bh, rh;
        biu_awvalid = (wq.size() != 0);
        if (wq.size() != 0) begin
            biu_awcid  = wq[0].cid;
            biu_awaddr = wq[0].addr;
            biu_awdata = wq[0].data;
            biu_awstrb = wq[0].strb;
        end
        biu_arvalid = (rq.size() != 0);
        if (rq.size() != 0) begin
            biu_arcid  = rq[0].cid;
            biu_araddr = rq[0].addr;
        end
        #1;
        chk("awvalid", AWVALID, awp.size() != 0);
        if (awp.size() != 0) begin
            chk("awaddr", AWADDR, awp[0].addr);
            chk("awid", AWID, {4'h0, awp[0].cid});
        end
        chk("wvalid", WVALID, wp.size() != 0);
        if (wp.size() != 0) begin
            chk("wdata", WDATA, wp[0].data);
            chk("wstrb", WSTRB, wp[0].strb);
        end
        chk("arvalid", ARVALID, arp.size() != 0);
        if (arp.size() != 0) begin
            chk("araddr", ARADDR, arp[0].addr);
            chk("arid", ARID, {4'h0, arp[0].cid});
        end
        wf = (awp.size() == 0 || AWREADY) && (wp.size() == 0 || WREADY);
        rf = (arp.size() == 0 || ARREADY);
        ep_w = wf && (wq.size() != 0) && (wcnt < MAX);
        ep_r = rf && (rq.size() != 0) && (rcnt < MAX);
        chk("awpop", biu_awpop, ep_w);
        chk("arpop", biu_arpop, ep_r);
        chk("wr_outst", wr_outst, wcnt);
        chk("rd_outst", rd_outst, rcnt);
        chk("bready", BREADY, biu_bready);
        chk("rready", RREADY, biu_rready);
        chk("bpush", biu_bpush, eb_push);
        if (eb_push) begin
            chk("bcid", biu_bcid, eb_cid);
            chk("bresp", biu_bresp, eb_resp);
        end
        chk("rpush", biu_rpush, er_push);
        if (er_push) begin
            chk("rcid", biu_rcid, er_cid);
            chk("rdata", biu_rdata, er_data);
            chk("rresp", biu_rresp, er_resp);
        end
        chk("idle", biu_idle, awp.size() == 0 && wp.size() == 0
            && arp.size() == 0 && wcnt == 0 && rcnt == 0);
`ifdef VXE_AXI4MAS_BIU_ERRCNT_EN
        chk("wr_errcnt", wr_errcnt, ew_err);
        chk("rd_errcnt", rd_errcnt, er_err);
`endif
        if (biu_awpop) nwpop++;
        if (biu_arpop) nrpop++;
        bh = BVALID && biu_bready;
        rh = RVALID && biu_rready;
        if (awp.size() != 0 && AWREADY) void'(awp.pop_front());
        if (wp.size() != 0 && WREADY) void'(wp.pop_front());
        if (arp.size() != 0 && ARREADY) void'(arp.pop_front());
        if (ep_w) begin
            awp.push_back(wq[0]);
            wp.push_back(wq[0]);
            void'(wq.pop_front());
            wcnt++;
        end
        if (ep_r) begin
            arp.push_back(rq[0]);
            void'(rq.pop_front());
            rcnt++;
        end
        if (bh && wcnt > 0) wcnt--;
        if (rh && rcnt > 0) rcnt--;
        eb_push = bh;
        if (bh) begin
            eb_cid = BID[3:0];
            eb_resp = BRESP;
        end
        er_push = rh;
        if (rh) begin
            er_cid = RID[3:0];
            er_data = RDATA;
            er_resp = RRESP;
        end
`ifdef VXE_AXI4MAS_BIU_ERRCNT_EN
        if (err_clr) begin
            ew_err = 0;
            er_err = 0;
        end else begin
            if (bh && BRESP[1] && ew_err < 65535) ew_err++;
            if (rh && RRESP[1] && er_err < 65535) er_err++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nw0, nr0;
        logic [4:0] ha, hw;
        AWREADY = 0; WREADY = 0; ARREADY = 0;
        BVALID = 0; BID = 0; BRESP = 0;
        RVALID = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 1;
        biu_awvalid = 0; biu_awcid = 0; biu_awaddr = 0;
        biu_awdata = 0; biu_awstrb = 0;
        biu_arvalid = 0; biu_arcid = 0; biu_araddr = 0;
        biu_bready = 1; biu_rready = 1;
        nwpop = 0; nrpop = 0;
        eb_cid = 0; eb_resp = 0; er_cid = 0; er_resp = 0; er_data = 0;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_bpush", biu_bpush, 0);
        chk("rst_rpush", biu_rpush, 0);
        chk("rst_wr_outst", wr_outst, 0);
        chk("rst_rd_outst", rd_outst, 0);
        chk("rst_awaddr", AWADDR, 0);
        chk("rst_awid", AWID, 0);
        chk("rst_wdata", WDATA, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_bcid", biu_bcid, 0);
        chk("rst_rdata", biu_rdata, 0);
        chk("rst_idle", biu_idle, 1);
        chk("awlen", AWLEN, 0);
        chk("awsize", AWSIZE, 2);
        chk("awburst", AWBURST, 0);
        chk("awprot", AWPROT, 3'b010);
        chk("wlast", WLAST, 1);
        chk("arsize", ARSIZE, 2);
        chk("arprot", ARPROT, 3'b010);
        rst = 0;

        // Three back-to-back writes into a ready slave.
        AWREADY = 1; WREADY = 1; ARREADY = 1;
        for (int i = 0; i < 3; i++)
            wq.push_back('{cid: 4'(i + 1), addr: 32'h1000 + 32'(i * 4),
                           data: 32'hA0 + 32'(i), strb: 4'hF});
        nw0 = nwpop;
        for (int i = 0; i < 5; i++) begin
            cyc();
            ha[i] = AWVALID;
        end
        chk("aw_3cyc", ha, 5'b00111);
        chk("w_pops3", nwpop - nw0, 3);
        chk("wr_outst3", wr_outst, 3);

        // Credit full: no issue until a B handshake frees one.
        wq.push_back('{cid: 4'h9, addr: 32'h2000, data: 32'h55,
                       strb: 4'h3});
        cyc(); cyc();
        chk("full_nopop", nwpop - nw0, 3);
        BVALID = 1; BID = 8'hA3; BRESP = 2'b00;
        cyc();
        BVALID = 0;
        chk("bcid_trunc", biu_bcid, 4'h3);
        chk("wr_after_b", wr_outst, 2);
        cyc();
        chk("wr_refill", wr_outst, 3);
        BVALID = 1;
        repeat (4) cyc();
        BVALID = 0;
        chk("wr_no_undf", wr_outst, 0);

        // Reads stall at the credit limit until one R completes.
        for (int i = 0; i < 4; i++)
            rq.push_back('{cid: 4'(i + 4), addr: 32'h3000 + 32'(i * 4)});
        nr0 = nrpop;
        repeat (5) cyc();
        chk("r_pops3", nrpop - nr0, 3);
        chk("rd_outst3", rd_outst, 3);
        RVALID = 1; RID = 8'h05; RDATA = 32'hDEADBEEF; RRESP = 2'b00;
        cyc();
        RVALID = 0;
        chk("rpush", biu_rpush, 1);
        chk("rcid5", biu_rcid, 4'h5);
        chk("rdata_db", biu_rdata, 32'hDEADBEEF);
        chk("rd_after_r", rd_outst, 2);
        cyc();
        chk("r_pops4", nrpop - nr0, 4);
        RVALID = 1;
        repeat (4) cyc();
        RVALID = 0;

        // AW accepted at once, W held off: no reissue until W completes.
        WREADY = 0;
        wq.push_back('{cid: 4'h1, addr: 32'h4000, data: 32'h11,
                       strb: 4'h1});
        wq.push_back('{cid: 4'h2, addr: 32'h4004, data: 32'h22,
                       strb: 4'h2});
        nw0 = nwpop;
        for (int i = 0; i < 5; i++) begin
            cyc();
            ha[i] = AWVALID;
            hw[i] = WVALID;
        end
        chk("aw_1cyc", ha, 5'b00001);
        chk("w_5cyc", hw, 5'b11111);
        chk("w_stall_pops", nwpop - nw0, 1);
        WREADY = 1;
        cyc();
        chk("w_reissue", nwpop - nw0, 2);
        chk("aw_reissue", AWVALID, 1);

        // Pop and B handshake in the same cycle leave the count alone.
        BVALID = 1; BRESP = 2'b00; BID = 8'h07;
        cyc();
        chk("wr_one", wr_outst, 1);
        wq.push_back('{cid: 4'h3, addr: 32'h5000, data: 32'h33,
                       strb: 4'hC});
        cyc();
        chk("pop_b_same", wr_outst, 1);

        // Response FIFO full holds off BREADY.
        biu_bready = 0; BRESP = 2'b10; BID = 8'h02;
        cyc();
        chk("bready_low", BREADY, 0);
        chk("no_bpush", biu_bpush, 0);
        biu_bready = 1;
        cyc();
        BVALID = 0;
        chk("bpush_err", biu_bpush, 1);
        chk("bresp_err", biu_bresp, 2'b10);
        chk("wr_zero", wr_outst, 0);
`ifdef VXE_AXI4MAS_BIU_ERRCNT_EN
        chk("wr_errcnt1", wr_errcnt, 1);
`endif

        // Random traffic against the model.
        repeat (500) begin
            if ($urandom_range(0, 2) == 0 && wq.size() < 4)
                wq.push_back('{cid: 4'($urandom), addr: $urandom,
                               data: $urandom, strb: 4'($urandom)});
            if ($urandom_range(0, 2) == 0 && rq.size() < 4)
                rq.push_back('{cid: 4'($urandom), addr: $urandom});
            AWREADY = ($urandom_range(0, 3) != 0);
            WREADY  = ($urandom_range(0, 3) != 0);
            ARREADY = ($urandom_range(0, 3) != 0);
            BVALID  = ($urandom_range(0, 2) == 0);
            BID     = 8'($urandom);
            BRESP   = 2'($urandom);
            RVALID  = ($urandom_range(0, 2) == 0);
            RID     = 8'($urandom);
            RDATA   = $urandom;
            RRESP   = 2'($urandom);
            biu_bready = ($urandom_range(0, 3) != 0);
            biu_rready = ($urandom_range(0, 3) != 0);
`ifdef VXE_AXI4MAS_BIU_ERRCNT_EN
            err_clr = ($urandom_range(0, 31) == 0);
`endif
            cyc();
        end
`ifdef VXE_AXI4MAS_BIU_ERRCNT_EN
        err_clr = 0;
`endif

        // Drain, then reset with reads in flight.
        wq.delete(); rq.delete();
        AWREADY = 1; WREADY = 1; ARREADY = 1;
        BVALID = 1; RVALID = 1; biu_bready = 1; biu_rready = 1;
        repeat (6) cyc();
        BVALID = 0; RVALID = 0;
        for (int i = 0; i < 3; i++)
            rq.push_back('{cid: 4'(i), addr: 32'h6000 + 32'(i * 4)});
        cyc(); cyc();
        ARREADY = 0;
        cyc();
        chk("pre_rst_arv", ARVALID, 1);
        chk("pre_rst_rd", rd_outst, 2);
        rst = 1;
        #1;
        chk("mid_rst_arv", ARVALID, 0);
        chk("mid_rst_rd", rd_outst, 0);
        chk("mid_rst_idle", biu_idle, 1);
        model_clear();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
